// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART controller with TX/RX byte FIFOs.
// Decodes core loads/stores to a 16-byte window at BASE_ADDR, schedules TX
// bytes onto the transmitter with valid/ready, and buffers received bytes.
// Optional feature macro: UART_MMIO_IRQ_EN (CTRL register and irq logic).
module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_PW = RX_AW + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_next;

  // Bus decode
  logic       wr_en, rd_en;
  logic [1:0] reg_sel;

  // TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] tx_wptr, tx_rptr;
  logic             tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;

  // RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] rx_wptr, rx_rptr;
  logic             rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set;
  logic [7:0]       rx_head;

  // Status / control
  logic        rx_overrun, tx_overflow, tx_busy;
  logic        status_wr, ctrl_wr;
  logic [31:0] status_word, ctrl_word;

  // Bits of the bus the register map never looks at
  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], WD[31:8]};

  // Address decode: window hit and register select
  assign Hit     = (Addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en   = Hit && (MemWrite != 2'b00);
  assign rd_en   = Hit && MemRead;
  assign reg_sel = Addr[3:2];

  assign status_wr = wr_en && (reg_sel == REG_STATUS);
  assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL);

  // FIFO flags: equal indices, wrap bits decide full vs empty
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]) &&
                    (tx_wptr[TX_AW] != tx_rptr[TX_AW]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]) &&
                    (rx_wptr[RX_AW] != rx_rptr[RX_AW]);

  // Push/pop qualification; fullness is judged on registered pointers only
  assign tx_push    = wr_en && (reg_sel == REG_TXDATA) && !tx_full;
  assign tx_ovf_set = wr_en && (reg_sel == REG_TXDATA) && tx_full;
  assign rx_push    = rx_valid && !rx_full;
  assign rx_ovr_set = rx_valid && rx_full;
  assign rx_pop     = rd_en && (reg_sel == REG_RXDATA) && !rx_empty;

  assign rx_head = rx_mem[rx_rptr[RX_AW-1:0]];

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr[TX_AW-1:0]] <= WD[7:0];
    end
  end

  // TX FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_PW'(1);
    end
  end

  // RX FIFO storage write
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr[RX_AW-1:0]] <= rx_data;
    end
  end

  // RX FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_PW'(1);
    end
  end

  // TX scheduler state register; tx_valid mirrors the SEND state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_next;
      tx_valid <= (state_next == SEND);
    end
  end

  // TX scheduler next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!tx_empty) state_next = SEND;
      SEND: if (tx_ready && tx_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // TX scheduler outputs: pop the FIFO head whenever a new byte is loaded
  always_comb begin
    tx_pop = 1'b0;
    case (state)
      IDLE: tx_pop = !tx_empty;
      SEND: tx_pop = tx_ready && !tx_empty;
      default: tx_pop = 1'b0;
    endcase
  end

  // Transmit byte register, held stable while waiting for tx_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data <= 8'h00;
    end else if (tx_pop) begin
      tx_data <= tx_mem[tx_rptr[TX_AW-1:0]];
    end
  end

  // Sticky error flags: write-1-to-clear, a same-cycle event wins over the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rx_ovr_set)              rx_overrun <= 1'b1;
      else if (status_wr && WD[4]) rx_overrun <= 1'b0;
      if (tx_ovf_set)              tx_overflow <= 1'b1;
      else if (status_wr && WD[5]) tx_overflow <= 1'b0;
    end
  end

  assign tx_busy = (state == SEND) || !tx_empty;

  assign status_word = {25'b0, tx_busy, tx_overflow, rx_overrun,
                        rx_full, rx_empty, tx_empty, tx_full};

`ifdef UART_MMIO_IRQ_EN
  logic rxie, txie;

  // Interrupt enable register
  always_ff @(posedge clk) begin
    if (reset) begin
      rxie <= 1'b0;
      txie <= 1'b0;
    end else if (ctrl_wr) begin
      rxie <= WD[0];
      txie <= WD[1];
    end
  end

  assign ctrl_word = {30'b0, txie, rxie};
  assign irq       = (rxie && !rx_empty) || (txie && tx_empty && (state == IDLE));
`else
  logic unused_ctrl;
  assign unused_ctrl = ctrl_wr;
  assign ctrl_word   = 32'h0;
  assign irq         = 1'b0;
`endif

  // Load data mux; zero outside the window or when no load is active
  always_comb begin
    RD = 32'h0;
    if (rd_en) begin
      case (reg_sel)
        REG_TXDATA: RD = 32'h0;
        REG_RXDATA: RD = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
        REG_STATUS: RD = status_word;
        REG_CTRL:   RD = ctrl_word;
        default:    RD = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_uart_mmio_ctrl;

`ifdef UART_MMIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [1:0]  MemWrite;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_mmio_ctrl dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Addr(Addr), .WD(WD), .RD(RD), .Hit(Hit), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_send;
  logic [7:0] m_held;
  bit         m_ovr, m_ovf;
  bit [1:0]   m_ctrl;
  bit         model_ok = 1'b0;

  function automatic bit m_hit();
    return Addr[31:4] == 28'h000_0040;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (txq.size() == DEPTH);
    s[1] = (txq.size() == 0);
    s[2] = (rxq.size() == 0);
    s[3] = (rxq.size() == DEPTH);
    s[4] = m_ovr;
    s[5] = m_ovf;
    s[6] = m_send || (txq.size() != 0);
    return s;
  endfunction

  function automatic logic [31:0] m_rd();
    if (!(m_hit() && MemRead)) return 32'h0;
    case (Addr[3:2])
      2'd1:    return (rxq.size() != 0) ? (32'h100 | 32'(rxq[0])) : 32'h0;
      2'd2:    return m_status();
      2'd3:    return 32'(m_ctrl);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_irq();
    return (m_ctrl[0] && rxq.size() != 0) ||
           (m_ctrl[1] && txq.size() == 0 && !m_send);
  endfunction

  task automatic model_step();
    bit st, ld, txpush, rxpush, rxpop;
    int txo, rxo;
    logic [1:0] r;
    logic [7:0] junk;
    if (reset) begin
      txq.delete(); rxq.delete();
      m_send = 0; m_held = 8'h00; m_ovr = 0; m_ovf = 0; m_ctrl = 2'b00;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    st  = m_hit() && (MemWrite != 2'b00);
    ld  = m_hit() && MemRead;
    r   = Addr[3:2];
    txo = txq.size();
    rxo = rxq.size();
    txpush = st && r == 2'd0 && txo < DEPTH;
    rxpush = rx_valid && rxo < DEPTH;
    rxpop  = ld && r == 2'd1 && rxo > 0;
    if (st && r == 2'd2) begin
      if (WD[4]) m_ovr = 0;
      if (WD[5]) m_ovf = 0;
    end
    if (st && r == 2'd0 && txo == DEPTH) m_ovf = 1;
    if (rx_valid && rxo == DEPTH) m_ovr = 1;
    if (st && r == 2'd3 && IRQ_EN) m_ctrl = WD[1:0];
    if (!m_send) begin
      if (txo > 0) begin m_held = txq.pop_front(); m_send = 1; end
    end else if (tx_ready) begin
      if (txo > 0) m_held = txq.pop_front();
      else m_send = 0;
    end
    if (txpush) txq.push_back(WD[7:0]);
    if (rxpop) junk = rxq.pop_front();
    if (rxpush) rxq.push_back(rx_data);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("hit", 32'(Hit), 32'(m_hit()));
      chk("tx_valid", 32'(tx_valid), 32'(m_send));
      if (m_send) chk("tx_data", 32'(tx_data), 32'(m_held));
      chk("irq", 32'(irq), 32'(m_irq()));
      if (MemRead) chk("rd", RD, m_rd());
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic [1:0] we, input logic re,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy,
                       input logic rv, input logic [7:0] rb);
    @(posedge clk);
    #1;
    reset = rst; MemWrite = we; MemRead = re; Addr = a; WD = d;
    tx_ready = rdy; rx_valid = rv; rx_data = rb;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rdy, 1'b0, 8'h00);
  endtask

  task automatic st(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                    input logic rdy);
    drive(1'b0, w, 1'b0, a, d, rdy, 1'b0, 8'h00);
  endtask

  task automatic ld(input logic [31:0] a, input logic rdy);
    drive(1'b0, 2'b00, 1'b1, a, 32'h0, rdy, 1'b0, 8'h00);
  endtask

  task automatic rxin(input logic [7:0] b, input logic rdy);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rdy, 1'b1, b);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 2'b00; MemRead = 1'b0; Addr = 32'h0; WD = 32'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00);
    idle(1'b0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    ld(32'h408, 1'b0);
    chk("reset_status", RD, 32'h06);

    // Single byte, latency N+2, one-cycle valid with tx_ready high
    st(2'b01, 32'h400, 32'h41, 1'b1);
    idle(1'b1);
    chk("lat_n1_valid", 32'(tx_valid), 32'h0);
    idle(1'b1);
    chk("lat_n2_valid", 32'(tx_valid), 32'h1);
    chk("lat_n2_data", 32'(tx_data), 32'h41);
    idle(1'b1);
    chk("lat_n3_valid", 32'(tx_valid), 32'h0);
    ld(32'h40A, 1'b1);
    chk("status_after_tx", RD, 32'h06);

    // Fill with tx_ready low, overflow on the 18th store
    for (int i = 0; i < 17; i++) st(2'((i % 3) + 1), 32'h400, 32'hCC00 | 32'(i), 1'b0);
    st(2'b11, 32'h403, 32'h11, 1'b0);
    ld(32'h408, 1'b0);
    chk("status_full_ovf", RD, 32'h65);
    chk("held_valid", 32'(tx_valid), 32'h1);
    chk("held_data", 32'(tx_data), 32'h00);
    for (int k = 0; k < 17; k++) begin
      idle(1'b1);
      chk("burst_valid", 32'(tx_valid), 32'h1);
      chk("burst_data", 32'(tx_data), 32'(k));
    end
    idle(1'b1);
    chk("burst_end_valid", 32'(tx_valid), 32'h0);
    st(2'b11, 32'h408, 32'h20, 1'b1);
    ld(32'h408, 1'b1);
    chk("ovf_cleared", RD, 32'h06);

    // RX read with and without data
    rxin(8'h5A, 1'b1);
    ld(32'h404, 1'b1);
    chk("rx_read", RD, 32'h15A);
    ld(32'h404, 1'b1);
    chk("rx_read_empty", RD, 32'h0);

    // Outside the window: no hit, no effect; TXDATA reads zero
    ld(32'h504, 1'b1);
    chk("miss_rd", RD, 32'h0);
    chk("miss_hit", 32'(Hit), 32'h0);
    st(2'b11, 32'h410, 32'h77, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("miss_no_tx", 32'(tx_valid), 32'h0);
    ld(32'h400, 1'b1);
    chk("txdata_rd", RD, 32'h0);
    chk("txdata_hit", 32'(Hit), 32'h1);

    // RX overrun: 17 pushes, first 16 retained
    for (int i = 0; i < 17; i++) rxin(8'(8'h80 + i), 1'b1);
    ld(32'h408, 1'b1);
    chk("status_rx_ovr", RD, 32'h1A);
    st(2'b11, 32'h408, 32'h10, 1'b1);
    ld(32'h408, 1'b1);
    chk("ovr_cleared", RD, 32'h0A);
    for (int i = 0; i < 16; i++) begin
      ld(32'h404, 1'b1);
      chk("rx_drain", RD, 32'h100 | 32'(8'h80 + i));
    end
    ld(32'h408, 1'b1);
    chk("status_drained", RD, 32'h06);

    // Interrupts
    st(2'b11, 32'h40C, 32'h1, 1'b1);
    rxin(8'h33, 1'b1);
    idle(1'b1);
    chk("irq_rx", 32'(irq), 32'(IRQ_EN));
    ld(32'h40C, 1'b1);
    chk("ctrl_rd", RD, IRQ_EN ? 32'h1 : 32'h0);
    ld(32'h404, 1'b1);
    chk("irq_rx_rd", RD, 32'h133);
    idle(1'b1);
    chk("irq_rx_clear", 32'(irq), 32'h0);
    st(2'b11, 32'h40C, 32'h2, 1'b1);
    idle(1'b1);
    chk("irq_tx", 32'(irq), 32'(IRQ_EN));
    st(2'b11, 32'h40C, 32'h0, 1'b1);
    idle(1'b1);
    chk("irq_off", 32'(irq), 32'h0);

    // Reset while in SEND with 3 bytes queued
    for (int i = 0; i < 4; i++) st(2'b01, 32'h400, 32'hA1 + 32'(i), 1'b0);
    idle(1'b0);
    chk("pre_rst_valid", 32'(tx_valid), 32'h1);
    chk("pre_rst_data", 32'(tx_data), 32'hA1);
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00);
    ld(32'h408, 1'b1);
    chk("rst_mid_valid", 32'(tx_valid), 32'h0);
    chk("rst_mid_status", RD, 32'h06);
    chk("rst_mid_data", 32'(tx_data), 32'h0);
    idle(1'b1);
    idle(1'b1);
    chk("rst_discard", 32'(tx_valid), 32'h0);

    idle(1'b0);
    idle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
